// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } st_e;

  typedef enum logic [2:0] {
    LT_LBU = 3'b000,
    LT_LHU = 3'b001,
    LT_LB  = 3'b100,
    LT_LH  = 3'b101,
    LT_LW  = 3'b110
  } lt_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } state_e;

  // Access width in bytes; invalid encodings fall back to 1 and are
  // rejected separately by valid_type.
  function automatic logic [2:0] size_bytes(logic we, logic [1:0] st, logic [2:0] lt);
    logic [2:0] n;
    n = 3'd1;
    if (we) begin
      case (st_e'(st))
        ST_SH:   n = 3'd2;
        ST_SW:   n = 3'd4;
        default: n = 3'd1;
      endcase
    end else begin
      case (lt_e'(lt))
        LT_LW:          n = 3'd4;
        LT_LH, LT_LHU:  n = 3'd2;
        default:        n = 3'd1;
      endcase
    end
    return n;
  endfunction

  function automatic logic valid_type(logic we, logic [1:0] st, logic [2:0] lt);
    logic ok;
    ok = 1'b0;
    if (we) begin
      ok = (st != 2'b11);
    end else begin
      case (lt_e'(lt))
        LT_LW, LT_LH, LT_LB, LT_LHU, LT_LBU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic load_signed(logic [2:0] lt);
    return (lt == LT_LB) || (lt == LT_LH);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: beat split, byte enables, write data shifting and
// load data merge/extension. Purely combinational.
module lsu_align (
  input  logic [1:0]  off,
  input  logic [2:0]  n,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic        beat1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata_ext
);

  logic [7:0]  mask_base;
  logic [7:0]  mask8;
  logic [63:0] wide_w;
  logic [31:0] merged;

  // Byte mask across the two candidate words touched by the access.
  always_comb begin
    case (n)
      3'd1:    mask_base = 8'h01;
      3'd2:    mask_base = 8'h03;
      default: mask_base = 8'h0F;
    endcase
    mask8 = mask_base << off;
    beat1 = |mask8[7:4];
    be0   = mask8[3:0];
    be1   = mask8[7:4];
  end

  // Store data moved onto its byte lanes; high word feeds the second beat.
  always_comb begin
    wide_w = {32'b0, wdata} << {off, 3'b000};
    wdata0 = wide_w[31:0];
    wdata1 = wide_w[63:32];
  end

  // Load data pulled back to bit 0 and extended to 32 bits.
  always_comb begin
    merged = 32'({rdata1, rdata0} >> {off, 3'b000});
    case (n)
      3'd1:    rdata_ext = sign_ext ? {{24{merged[7]}}, merged[7:0]}
                                    : {24'b0, merged[7:0]};
      3'd2:    rdata_ext = sign_ext ? {{16{merged[15]}}, merged[15:0]}
                                    : {16'b0, merged[15:0]};
      default: rdata_ext = merged;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: takes one core request, issues one or two word-aligned
// memory beats, and returns a single merged response.
//
// state | meaning
// IDLE  | ready for a core request
// CHK   | validate type / misalignment of the registered request
// REQ0  | beat 0 presented on the memory port until granted
// WAIT0 | beat 0 outstanding, waiting for completion
// REQ1  | beat 1 presented on the memory port until granted
// WAIT1 | beat 1 outstanding, waiting for completion
// RESP  | one-cycle response to the core
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_st,
  input  logic [2:0]  req_lt,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  st_q, st_d;
  logic [2:0]  lt_q, lt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err_q, err_d;

  logic        beat1;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, rdata_ext;
  logic [31:0] word_addr;

  assign word_addr = {addr_q[31:2], 2'b00};

  lsu_align u_align (
    .off       (addr_q[1:0]),
    .n         (size_bytes(we_q, st_q, lt_q)),
    .sign_ext  (load_signed(lt_q)),
    .wdata     (wdata_q),
    .rdata0    (rdata0_q),
    .rdata1    (rdata1_q),
    .beat1     (beat1),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .rdata_ext (rdata_ext)
  );

  // State register and request/response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      st_q     <= 2'b00;
      lt_q     <= 3'b000;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      rdata0_q <= 32'b0;
      rdata1_q <= 32'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      st_q     <= st_d;
      lt_q     <= lt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
    end
  end

  // Next-state, datapath updates and port outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    st_d       = st_q;
    lt_d       = lt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    err_d      = err_q;
    req_ready  = (state_q == S_IDLE) && rst_n;
    resp_valid = 1'b0;
    resp_rdata = 32'b0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0;
    mem_addr   = 32'b0;
    mem_wdata  = 32'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = S_CHK;
          we_d     = req_we;
          st_d     = req_st;
          lt_d     = req_lt;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          // Cleared here so a single-beat load merges against zero.
          rdata0_d = 32'b0;
          rdata1_d = 32'b0;
          err_d    = 1'b0;
        end
      end
      S_CHK: begin
        if (!valid_type(we_q, st_q, lt_q) || (!ALLOW_MISALIGNED && beat1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_REQ0;
        end
      end
      S_REQ0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_be    = be0;
        mem_addr  = word_addr;
        mem_wdata = wdata0;
        if (mem_gnt) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          rdata0_d = mem_rdata;
          state_d  = beat1 ? S_REQ1 : S_RESP;
        end
      end
      S_REQ1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_be    = be1;
        mem_addr  = word_addr + 32'd4;
        mem_wdata = wdata1;
        if (mem_gnt) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          rdata1_d = mem_rdata;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'b0 : rdata_ext;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a byte-level reference memory.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_st;
  logic [2:0]  req_lt;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        nm_req_valid, nm_req_ready, nm_req_we;
  logic [1:0]  nm_req_st;
  logic [2:0]  nm_req_lt;
  logic [31:0] nm_req_addr, nm_req_wdata;
  logic        nm_resp_valid, nm_resp_err;
  logic [31:0] nm_resp_rdata;
  logic        nm_mem_req, nm_mem_gnt, nm_mem_we, nm_mem_rvalid;
  logic [3:0]  nm_mem_be;
  logic [31:0] nm_mem_addr, nm_mem_wdata, nm_mem_rdata;

  lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_st(req_st), .req_lt(req_lt), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b0)) u_dut_nm (
    .clk(clk), .rst_n(rst_n),
    .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_we(nm_req_we),
    .req_st(nm_req_st), .req_lt(nm_req_lt), .req_addr(nm_req_addr), .req_wdata(nm_req_wdata),
    .resp_valid(nm_resp_valid), .resp_rdata(nm_resp_rdata), .resp_err(nm_resp_err),
    .mem_req(nm_mem_req), .mem_gnt(nm_mem_gnt), .mem_we(nm_mem_we), .mem_be(nm_mem_be),
    .mem_addr(nm_mem_addr), .mem_wdata(nm_mem_wdata),
    .mem_rvalid(nm_mem_rvalid), .mem_rdata(nm_mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  resp_t resp_q[$];
  beat_t beat_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [7:0]  ref_mem[logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int n_resp   = 0;
  int n_gnt    = 0;
  bit zw       = 1'b1;
  bit hold_rv  = 1'b0;
  int stall_n  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] w);
    logic [31:0] v;
    if (mem.exists(w)) return mem[w];
    for (int i = 0; i < 4; i++) v[8*i +: 8] = init_byte(w + 32'(i));
    return v;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[w + 32'(i)] = v[8*i +: 8];
  endtask

  // Reference model: walks the accessed bytes one by one and groups them
  // into the words they live in.
  task automatic model_push(input bit we, input logic [1:0] st, input logic [2:0] lt,
                            input logic [31:0] a, input logic [31:0] wd, input bit lat_ok);
    int          n;
    int          nb;
    beat_t       b[2];
    logic [31:0] ba, w, val;
    resp_t       r;
    if (we) n = (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : (st == 2'd2) ? 4 : 0;
    else if (lt == 3'b110) n = 4;
    else if (lt == 3'b101 || lt == 3'b001) n = 2;
    else if (lt == 3'b100 || lt == 3'b000) n = 1;
    else n = 0;
    if (n == 0) begin
      r.rdata = 32'b0; r.err = 1'b1; r.lat = 2;
      resp_q.push_back(r);
      return;
    end
    nb  = 0;
    val = 32'b0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      w  = {ba[31:2], 2'b00};
      if (nb == 0 || b[nb-1].addr != w) begin
        b[nb].addr = w; b[nb].be = 4'b0; b[nb].we = we; b[nb].wdata = 32'b0;
        nb++;
      end
      b[nb-1].be[ba[1:0]] = 1'b1;
      b[nb-1].wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
      if (we) ref_mem[ba] = wd[8*i +: 8];
      else    val[8*i +: 8] = ref_byte(ba);
    end
    if (!we && lt == 3'b100) val = {{24{val[7]}}, val[7:0]};
    if (!we && lt == 3'b101) val = {{16{val[15]}}, val[15:0]};
    for (int i = 0; i < nb; i++) beat_q.push_back(b[i]);
    r.rdata = we ? 32'b0 : val;
    r.err   = 1'b0;
    r.lat   = lat_ok ? ((nb == 2) ? 6 : 4) : -1;
    resp_q.push_back(r);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (resp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (resp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: got no response expected %0d pending", resp_q.size());
      resp_q.delete();
      beat_q.delete();
    end
  endtask

  task automatic issue(input bit we, input logic [1:0] st, input logic [2:0] lt,
                       input logic [31:0] a, input logic [31:0] wd, input bit wait_done);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    model_push(we, st, lt, a, wd, zw && stall_n == 0);
    req_valid = 1'b1; req_we = we; req_st = st; req_lt = lt;
    req_addr = a; req_wdata = wd;
    t_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (wait_done) wait_idle();
  endtask

  // Response monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        n_resp++;
        if (resp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          if (e.lat >= 0) chk("resp_latency", 32'(cyc - t_acc), 32'(e.lat));
        end
      end
    end
  end

  // Memory responder: grants, checks beats, applies writes, returns data.
  initial begin
    int    rv_cnt;
    logic [31:0] rv_data, word, lmask;
    bit    have_snap, g;
    beat_t snap, e;
    rv_cnt = 0; rv_data = 32'b0; have_snap = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) have_snap = 1'b0;
      if (rv_cnt > 0 && !hold_rv) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
        end
      end else if (rv_cnt == 0 && mem_req === 1'b1 && rst_n) begin
        if (have_snap) begin
          chk("stall_addr", mem_addr, snap.addr);
          chk("stall_be", 32'(mem_be), 32'(snap.be));
          chk("stall_wdata", mem_wdata, snap.wdata);
        end
        g = (stall_n == 0) && (zw || $urandom_range(0, 2) != 0);
        if (stall_n > 0) stall_n--;
        if (g) begin
          mem_gnt = 1'b1;
          have_snap = 1'b0;
          n_gnt++;
          if (beat_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_mem_req: got addr %h expected no access", mem_addr);
          end else begin
            e = beat_q.pop_front();
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_be", 32'(mem_be), 32'(e.be));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            for (int i = 0; i < 4; i++) lmask[8*i +: 8] = {8{e.be[i]}};
            chk("mem_wdata", mem_wdata & lmask, e.wdata & lmask);
          end
          word = rd_word(mem_addr);
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) word[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_addr] = word;
            rv_data = $urandom;
          end else begin
            rv_data = word;
          end
          rv_cnt = zw ? 1 : int'($urandom_range(1, 3));
        end else begin
          have_snap = 1'b1;
          snap.addr = mem_addr; snap.be = mem_be; snap.we = mem_we; snap.wdata = mem_wdata;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic [31:0] a;
    logic [2:0]  lts[5];
    int          g0, r0, k, lat;
    bit          seen_req;
    lts = '{3'b110, 3'b101, 3'b100, 3'b001, 3'b000};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_st = 2'b0; req_lt = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0;
    nm_req_valid = 1'b0; nm_req_we = 1'b0; nm_req_st = 2'b0; nm_req_lt = 3'b0;
    nm_req_addr = 32'b0; nm_req_wdata = 32'b0;
    nm_mem_gnt = 1'b0; nm_mem_rvalid = 1'b0; nm_mem_rdata = 32'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_nm_req_ready", 32'(nm_req_ready), 32'd1);

    // Directed cases with zero-wait memory.
    zw = 1'b1;
    preload(32'h100, 32'h89ABCDEF);
    issue(1'b0, 2'b00, 3'b110, 32'h100, 32'h0, 1'b1);
    preload(32'h100, 32'h80FFFFFF);
    issue(1'b0, 2'b00, 3'b100, 32'h103, 32'h0, 1'b1);
    issue(1'b0, 2'b00, 3'b000, 32'h103, 32'h0, 1'b1);
    issue(1'b1, 2'b01, 3'b000, 32'h203, 32'h0000BEEF, 1'b1);
    issue(1'b0, 2'b00, 3'b001, 32'h203, 32'h0, 1'b1);
    preload(32'hFFFFFFFC, 32'h11225566);
    preload(32'h00000000, 32'h77883344);
    issue(1'b0, 2'b00, 3'b110, 32'hFFFFFFFE, 32'h0, 1'b1);
    issue(1'b0, 2'b00, 3'b011, 32'h100, 32'h0, 1'b1);
    issue(1'b1, 2'b11, 3'b000, 32'h100, 32'h12345678, 1'b1);

    // Misalignment rejected when splitting is disabled.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      nm_req_valid = 1'b1;
      nm_req_we    = (c == 0);
      nm_req_st    = 2'b10;
      nm_req_lt    = 3'b101;
      nm_req_addr  = (c == 0) ? 32'h001 : 32'h003;
      nm_req_wdata = 32'hCAFEF00D;
      k = cyc;
      @(negedge clk);
      nm_req_valid = 1'b0;
      seen_req = 1'b0;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
        if (nm_mem_req) seen_req = 1'b1;
        if (nm_resp_valid) begin
          lat = cyc - k;
          chk("nm_resp_err", 32'(nm_resp_err), 32'd1);
          chk("nm_resp_rdata", nm_resp_rdata, 32'd0);
          break;
        end
        @(negedge clk);
      end
      chk("nm_latency", 32'(lat), 32'd2);
      chk("nm_mem_req_seen", 32'(seen_req), 32'd0);
    end

    // Stall in REQ0 for 5 cycles on a split store.
    stall_n = 5;
    issue(1'b1, 2'b10, 3'b000, 32'h302, 32'hA1B2C3D4, 1'b1);
    issue(1'b0, 2'b00, 3'b110, 32'h302, 32'h0, 1'b1);

    // Reset while waiting for completion, then a stale completion.
    hold_rv = 1'b1;
    g0 = n_gnt;
    issue(1'b0, 2'b00, 3'b110, 32'h300, 32'h0, 1'b0);
    k = 0;
    while (n_gnt == g0 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reset_test_granted", 32'(n_gnt - g0), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    resp_q.delete();
    beat_q.delete();
    r0 = n_resp;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    hold_rv = 1'b0;
    chk("after_rst_req_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("no_resp_after_reset", 32'(n_resp - r0), 32'd0);
    issue(1'b0, 2'b00, 3'b110, 32'h300, 32'h0, 1'b1);

    // Randomized traffic with random grant/completion timing.
    zw = 1'b0;
    for (int it = 0; it < 250; it++) begin
      we = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      lt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : lts[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                       : 32'h400 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) zw = 1'b1; else zw = 1'b0;
      issue(we, st, lt, a, $urandom, 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
